// File: rtl/train_phase_sched_if.sv
// Host/datapath-facing bundle of the training phase scheduler: control inputs,
// status outputs and datapath mux selects.
interface train_phase_sched_if #(
  parameter int NUM_LAYERS = 4,
  parameter int BATCH_W    = 8
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                  start;
  logic                  abort;
  logic                  hold;
  logic [BATCH_W-1:0]    batch_size;
  logic [NUM_LAYERS-1:0] stride_cfg;
  logic                  busy;
  logic                  done;
  logic [1:0]            phase;
  logic [LW-1:0]         layer_idx;
  logic [BATCH_W-1:0]    sample_idx;
  logic                  stride;
  logic                  select_m0;
  logic                  select_m1;
  logic                  select_m2;
  logic                  select_m3;
  logic                  select0;
  logic                  select1;

  modport master (
    output start, abort, hold, batch_size, stride_cfg,
    input  busy, done, phase, layer_idx, sample_idx, stride,
    input  select_m0, select_m1, select_m2, select_m3, select0, select1
  );

  modport slave (
    input  start, abort, hold, batch_size, stride_cfg,
    output busy, done, phase, layer_idx, sample_idx, stride,
    output select_m0, select_m1, select_m2, select_m3, select0, select1
  );
endinterface

// File: rtl/train_phase_sched.sv
// Batch scheduler: runs each sample through FP (ascending), BP and WG (descending) over the layer stack.
// Optional SCHED_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module train_phase_sched #(
  parameter int PHASE_LEN  = 11,
  parameter int NUM_LAYERS = 4,
  parameter int BATCH_W    = 8
) (
  input  logic               clk,
  input  logic               fsm_rst_n,
  train_phase_sched_if.slave bus
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CW = $clog2(PHASE_LEN);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(PHASE_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, FP = 2'b01, BP = 2'b10, WG = 2'b11} state_t;

  state_t                state_r, state_s;
  logic [LW-1:0]         layer_r, layer_s;
  logic [BATCH_W-1:0]    sample_r, sample_s;
  logic [BATCH_W-1:0]    batch_r, batch_s;
  logic [NUM_LAYERS-1:0] stride_cfg_r, stride_cfg_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic                  done_r, done_s;
  logic                  busy_r, busy_s;
  logic                  accept_s;
  logic                  stride_s;
  logic [5:0]            sel_s;

  // Next-state, counters and configuration capture
  always_comb begin
    state_s      = state_r;
    layer_s      = layer_r;
    sample_s     = sample_r;
    batch_s      = batch_r;
    stride_cfg_s = stride_cfg_r;
    cnt_s        = cnt_r;
    done_s       = 1'b0;
    accept_s     = 1'b0;
    if (bus.abort) begin
      state_s  = IDLE;
      layer_s  = '0;
      sample_s = '0;
      cnt_s    = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && (bus.batch_size != '0)) begin
            accept_s     = 1'b1;
            state_s      = FP;
            layer_s      = '0;
            sample_s     = '0;
            cnt_s        = '0;
            batch_s      = bus.batch_size;
            stride_cfg_s = bus.stride_cfg;
          end else if (bus.start) begin
            done_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        FP, BP, WG: begin
          if (bus.hold) begin
            cnt_s = cnt_r;
          end else if (cnt_r != LAST_CNT) begin
            cnt_s = cnt_r + 1'b1;
          end else begin
            cnt_s = '0;
            case (state_r)
              FP: begin
                if (layer_r != LAST_LAYER) begin
                  layer_s = layer_r + 1'b1;
                end else begin
                  state_s = BP;
                  layer_s = LAST_LAYER;
                end
              end
              BP: begin
                if (layer_r != '0) begin
                  layer_s = layer_r - 1'b1;
                end else begin
                  state_s = WG;
                  layer_s = LAST_LAYER;
                end
              end
              WG: begin
                if (layer_r != '0) begin
                  layer_s = layer_r - 1'b1;
                end else if (sample_r != (batch_r - 1'b1)) begin
                  state_s  = FP;
                  sample_s = sample_r + 1'b1;
                  layer_s  = '0;
                end else begin
                  // Batch complete: leave counters clean for the next batch
                  state_s  = IDLE;
                  sample_s = '0;
                  done_s   = 1'b1;
                end
              end
              default: state_s = IDLE;
            endcase
          end
        end
        default: state_s = IDLE;
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State, counters, captured configuration and status registers
  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state_r      <= IDLE;
      layer_r      <= '0;
      sample_r     <= '0;
      batch_r      <= '0;
      stride_cfg_r <= '0;
      cnt_r        <= '0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      layer_r      <= layer_s;
      sample_r     <= sample_s;
      batch_r      <= batch_s;
      stride_cfg_r <= stride_cfg_s;
      cnt_r        <= cnt_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
    end
  end

  assign stride_s = stride_cfg_r[layer_r];

  // Datapath mux decode from phase and the current layer's stride
  always_comb begin
    sel_s = 6'b000000;
    case (state_r)
      FP:      sel_s = {stride_s, stride_s, 1'b0, 1'b0, 1'b0, 1'b1};
      BP:      sel_s = {5'b00000, ~stride_s};
      WG:      sel_s = {stride_s, stride_s, 1'b1, 1'b1, 1'b1, 1'b0};
      default: sel_s = 6'b000000;
    endcase
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.phase      = state_r;
  assign bus.layer_idx  = layer_r;
  assign bus.sample_idx = sample_r;
  assign bus.stride     = stride_s;
  assign bus.select_m0  = sel_s[5];
  assign bus.select_m1  = sel_s[4];
  assign bus.select_m2  = sel_s[3];
  assign bus.select_m3  = sel_s[2];
  assign bus.select0    = sel_s[1];
  assign bus.select1    = sel_s[0];

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_r;

  // Busy-cycle counter: cleared on accept, saturating, frozen while idle
  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      perf_r <= 32'd0;
    end else if (accept_s) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`endif
endmodule

// File: tb/tb_train_phase_sched.sv
// Scoreboard bench: a small (2 layers, 3-cycle phase) and a default-sized scheduler,
// expected per-cycle schedule queued at start and popped every busy cycle.
module tb_train_phase_sched;
  localparam int S_NL = 2;
  localparam int S_PL = 3;
  localparam int D_NL = 4;
  localparam int D_PL = 11;
  localparam int BW   = 8;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] phase;
    logic [1:0] layer;
    logic [7:0] sample;
    logic       stride;
    logic [5:0] sel;
  } obs_t;

  logic       clk = 1'b0;
  logic       fsm_rst_n = 1'b0;
  logic [1:0] in_start, in_abort, in_hold;
  logic [7:0] in_bs [2];
  logic [3:0] in_cfg [2];
  int         n_cmp = 0;
  int         n_bad = 0;
  obs_t       sbq [$];
  logic [31:0] last_perf = 32'd0;

  always #5 clk = ~clk;

  train_phase_sched_if #(.NUM_LAYERS(S_NL), .BATCH_W(BW)) sb ();
  train_phase_sched_if #(.NUM_LAYERS(D_NL), .BATCH_W(BW)) db ();

  assign sb.start = in_start[0];
  assign sb.abort = in_abort[0];
  assign sb.hold  = in_hold[0];
  assign sb.batch_size = in_bs[0];
  assign sb.stride_cfg = in_cfg[0][1:0];
  assign db.start = in_start[1];
  assign db.abort = in_abort[1];
  assign db.hold  = in_hold[1];
  assign db.batch_size = in_bs[1];
  assign db.stride_cfg = in_cfg[1];

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_s, perf_d;
  train_phase_sched #(.PHASE_LEN(S_PL), .NUM_LAYERS(S_NL), .BATCH_W(BW)) u_small (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(sb), .perf_cycles(perf_s));
  train_phase_sched #(.PHASE_LEN(D_PL), .NUM_LAYERS(D_NL), .BATCH_W(BW)) u_dflt (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(db), .perf_cycles(perf_d));
`else
  train_phase_sched #(.PHASE_LEN(S_PL), .NUM_LAYERS(S_NL), .BATCH_W(BW)) u_small (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(sb));
  train_phase_sched #(.PHASE_LEN(D_PL), .NUM_LAYERS(D_NL), .BATCH_W(BW)) u_dflt (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(db));
`endif

  function automatic logic [5:0] sel_model(input logic [1:0] ph, input logic st);
    case (ph)
      2'b01:   return {st, st, 1'b0, 1'b0, 1'b0, 1'b1};
      2'b10:   return {5'b00000, ~st};
      2'b11:   return {st, st, 1'b1, 1'b1, 1'b1, 1'b0};
      default: return 6'b000000;
    endcase
  endfunction

  function automatic obs_t obs(input int which);
    obs_t o;
    if (which == 0) begin
      o.busy = sb.busy;  o.done = sb.done;  o.phase = sb.phase;
      o.layer = 2'(sb.layer_idx);  o.sample = sb.sample_idx;  o.stride = sb.stride;
      o.sel = {sb.select_m0, sb.select_m1, sb.select_m2, sb.select_m3, sb.select0, sb.select1};
    end else begin
      o.busy = db.busy;  o.done = db.done;  o.phase = db.phase;
      o.layer = 2'(db.layer_idx);  o.sample = db.sample_idx;  o.stride = db.stride;
      o.sel = {db.select_m0, db.select_m1, db.select_m2, db.select_m3, db.select0, db.select1};
    end
    return o;
  endfunction

  task automatic push_batch(input int nl, input int pl, input int bsize, input logic [3:0] scfg);
    for (int s = 0; s < bsize; s++)
      for (int p = 1; p <= 3; p++)
        for (int i = 0; i < nl; i++) begin
          int   l;
          obs_t e;
          l = (p == 1) ? i : nl - 1 - i;
          for (int c = 0; c < pl; c++) begin
            e.busy = 1'b1;  e.done = 1'b0;  e.phase = 2'(p);  e.layer = 2'(l);
            e.sample = 8'(s);  e.stride = scfg[l];  e.sel = sel_model(2'(p), scfg[l]);
            sbq.push_back(e);
          end
        end
  endtask

  // Pops one expected entry per busy cycle (repeats it after a held edge), then checks done.
  task automatic drain(input int which, input int start_clr, input int hold_at, input int hold_len,
                       input int abort_at, input bit chain, output int nbusy);
    obs_t o, cur, e_idle;
    bit   held;
    int   k, hleft;
    held = 1'b0;  k = 0;  hleft = 0;  nbusy = 0;  cur = '0;
    e_idle = '0;  e_idle.done = 1'b1;
    for (int guard = 0; guard < 3000; guard++) begin
      @(negedge clk);
      o = obs(which);
      k++;
      if (k >= start_clr) in_start[which] = 1'b0;
      if (!held) begin
        if (sbq.size() == 0) begin
          o.stride = 1'b0;
          n_cmp++;
          if (o !== e_idle) begin
            n_bad++;
            $display("FAIL done_w%0d: got %h want %h", which, o, e_idle);
          end
`ifdef SCHED_PERF_CNT_EN
          last_perf = (which == 0) ? perf_s : perf_d;
`endif
          if (!chain) begin
            @(negedge clk);
            o = obs(which);
            o.stride = 1'b0;
            n_cmp++;
            if (o !== obs_t'(0)) begin
              n_bad++;
              $display("FAIL done_pulse_w%0d: got %h want 0", which, o);
            end
          end
          return;
        end
        cur = sbq.pop_front();
      end
      n_cmp++;
      if (o !== cur) begin
        n_bad++;
        $display("FAIL sched_w%0d cyc %0d: got %h want %h", which, k, o, cur);
      end
      nbusy++;
      if (k == abort_at) begin
        in_abort[which] = 1'b1;
        in_hold[which]  = 1'b1;
        sbq.delete();
        return;
      end
      if (k == hold_at) hleft = hold_len;
      held = (hleft > 0);
      in_hold[which] = held;
      if (hleft > 0) hleft--;
    end
    n_bad++;
    $display("FAIL timeout_w%0d: got %0d queued entries left, want 0", which, sbq.size());
  endtask

  task automatic check_idle(input int which, input string name);
    obs_t o;
    o = obs(which);
    o.stride = 1'b0;
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL %s: got %h want 0", name, o);
    end
  endtask

  task automatic check_len(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic start_batch(input int which, input int nl, input int pl, input int bsize, input logic [3:0] scfg);
    push_batch(nl, pl, bsize, scfg);
    in_bs[which] = 8'(bsize);
    in_cfg[which] = scfg;
    in_start[which] = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      o = obs(w);
      n_cmp++;
      if (o !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset_w%0d: got %h want 0", w, o);
      end
    end
    fsm_rst_n = 1'b1;
  endtask

  task automatic test_single_batch();
    int nb;
    start_batch(0, S_NL, S_PL, 1, 4'b0010);
    drain(0, 1, -1, 0, -1, 1'b0, nb);
    check_len("busy_len_single", nb, 18);
  endtask

  task automatic test_batch3_default();
    int nb;
    start_batch(1, D_NL, D_PL, 3, 4'b0110);
    drain(1, 1, -1, 0, -1, 1'b0, nb);
    check_len("busy_len_batch3", nb, 3 * 3 * D_NL * D_PL);
  endtask

  task automatic test_hold_and_reconfig();
    int nb;
    start_batch(0, S_NL, S_PL, 2, 4'b0001);
    fork
      begin
        @(posedge clk);
        #1;
        in_bs[0]  = 8'd7;
        in_cfg[0] = 4'b1110;
      end
    join_none
    // start stays high for several busy cycles and must be ignored
    drain(0, 8, 8, 5, -1, 1'b0, nb);
    check_len("busy_len_hold", nb, 2 * 18 + 5);
  endtask

  task automatic test_abort();
    int nb;
    start_batch(0, S_NL, S_PL, 2, 4'b0011);
    drain(0, 1, -1, 0, 14, 1'b0, nb);
    @(negedge clk);
    check_idle(0, "abort_idle");
    in_abort[0] = 1'b0;
    in_hold[0]  = 1'b0;
    @(negedge clk);
    check_idle(0, "abort_no_done");
    start_batch(0, S_NL, S_PL, 1, 4'b0010);
    drain(0, 1, -1, 0, -1, 1'b0, nb);
    check_len("busy_len_after_abort", nb, 18);
  endtask

  task automatic test_abort_final();
    int nb;
    start_batch(0, S_NL, S_PL, 1, 4'b0001);
    drain(0, 1, -1, 0, 18, 1'b0, nb);
    @(negedge clk);
    check_idle(0, "abort_final_idle");
    in_hold[0]  = 1'b0;
    in_bs[0]    = 8'd1;
    in_start[0] = 1'b1;
    @(negedge clk);
    check_idle(0, "abort_in_idle");
    in_abort[0] = 1'b0;
    in_start[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "abort_in_idle_after");
  endtask

  task automatic test_zero_batch();
    obs_t o, e;
    in_bs[0]    = 8'd0;
    in_start[0] = 1'b1;
    @(negedge clk);
    in_start[0] = 1'b0;
    o = obs(0);
    o.stride = 1'b0;
    e = '0;
    e.done = 1'b1;
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL zero_batch_done: got %h want %h", o, e);
    end
    @(negedge clk);
    check_idle(0, "zero_batch_after");
  endtask

  task automatic test_back_to_back();
    int nb;
    start_batch(0, S_NL, S_PL, 1, 4'b0010);
    drain(0, 1, -1, 0, -1, 1'b1, nb);
    start_batch(0, S_NL, S_PL, 1, 4'b0001);
    drain(0, 1, -1, 0, -1, 1'b0, nb);
    check_len("busy_len_back_to_back", nb, 18);
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_perf();
    int nb;
    start_batch(0, S_NL, S_PL, 1, 4'b0010);
    drain(0, 1, 4, 4, -1, 1'b0, nb);
    check_len("busy_len_perf", nb, 22);
    check_len("perf_at_done", int'(last_perf), 22);
    check_len("perf_idle_hold", int'(perf_s), 22);
  endtask
`endif

  task automatic test_reset_mid();
    start_batch(0, S_NL, S_PL, 1, 4'b0011);
    sbq.delete();
    @(negedge clk);
    in_start[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    fsm_rst_n = 1'b0;
    #1;
    check_idle(0, "reset_mid_immediate");
    @(negedge clk);
    check_idle(0, "reset_mid_no_done");
    fsm_rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "reset_mid_after_release");
  endtask

  initial begin
    in_start = 2'b00;
    in_abort = 2'b00;
    in_hold  = 2'b00;
    for (int w = 0; w < 2; w++) begin
      in_bs[w]  = 8'd0;
      in_cfg[w] = 4'd0;
    end
    test_reset();
    test_single_batch();
    test_batch3_default();
    test_hold_and_reconfig();
    test_abort();
    test_abort_final();
    test_zero_batch();
    test_back_to_back();
`ifdef SCHED_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/train_phase_sched.md
# train_phase_sched

Batch-level scheduler for the training datapath. On `start` it runs every sample of a batch through the layer stack in three passes: forward (FP, layers ascending), backward (BP, layers descending) and weight-gradient (WG, layers descending). For each phase it drives the datapath mux selects and the per-layer stride. It sits between the host control registers and the PE/mux datapath, and raises `done` when the batch completes.

## Interface
- `PHASE_LEN`, 11, cycles spent in one phase of one layer (minimum 2).
- `NUM_LAYERS`, 4, layers in the stack (minimum 1).
- `BATCH_W`, 8, width of the batch-size field.
- `clk`  in  1  clock. All state updates on the rising edge.
- `fsm_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run a batch. Sampled only in IDLE.
- `abort`  in  1  return to IDLE on the next edge. Overrides every other input.
- `hold`  in  1  datapath back-pressure. Freezes all counters and state.
- `batch_size`  in  BATCH_W  samples per batch. Captured when `start` is accepted.
- `stride_cfg`  in  NUM_LAYERS  per-layer stride bit. Captured when `start` is accepted.
- `busy`  out  1  high in FP, BP and WG.
- `done`  out  1  one-cycle pulse at batch completion.
- `phase`  out  2  00 IDLE, 01 FP, 10 BP, 11 WG.
- `layer_idx`  out  clog2(NUM_LAYERS), minimum 1  current layer.
- `sample_idx`  out  BATCH_W  current sample.
- `stride`  out  1  captured stride bit of `layer_idx`.
- `select_m0`, `select_m1`, `select_m2`, `select_m3`, `select0`, `select1`  out  1 each  datapath mux selects.

## Operation
- **States:** IDLE, FP, BP, WG.
- **Reset:** state IDLE. All counters, captured configuration, `done`, `busy`, `phase` and all selects are 0.
- **IDLE:**
  - `start` with `batch_size` != 0: capture configuration; go to FP with layer 0, sample 0, `phase_cnt` 0.
  - `start` with `batch_size` == 0: stay in IDLE and pulse `done` on the next cycle.
- **Phase counter:** `phase_cnt` runs 0..PHASE_LEN-1. At PHASE_LEN-1 with `hold` low, it returns to 0 and the scheduler advances:
  - FP: if layer < NUM_LAYERS-1, layer+1; otherwise go to BP with layer NUM_LAYERS-1.
  - BP: if layer > 0, layer-1; otherwise go to WG with layer NUM_LAYERS-1.
  - WG: if layer > 0, layer-1. Otherwise, if sample < batch_size-1, go to FP with sample+1 and layer 0. Otherwise go to IDLE and pulse `done`.
- **Select decode** (combinational from state and `stride`):
  - IDLE: all selects 0.
  - FP: `select_m0` = `select_m1` = `stride`; `select_m2` = `select_m3` = 0; `select0` = 0; `select1` = 1.
  - BP: `select_m0`..`select_m3` = 0; `select0` = 0; `select1` = ~`stride`.
  - WG: `select_m0` = `select_m1` = `stride`; `select_m2` = `select_m3` = 1; `select0` = 1; `select1` = 0.
- **Boundary conditions:**
  - `start` while busy: ignored.
  - `stride_cfg` or `batch_size` changing mid-batch: no effect.
  - `abort` in the same cycle as the final advance: goes to IDLE with no `done`.
  - `hold` and `abort` together: abort wins.
  - `abort` in IDLE: no effect.

## Timing
- First FP cycle is the cycle after `start` is accepted.
- Busy duration with `hold` low is batch_size × 3 × NUM_LAYERS × PHASE_LEN cycles. Each cycle with `hold` high adds one cycle.
- `done` is registered. It is high in the first IDLE cycle after the last WG cycle, and for exactly one cycle.
- A `start` in the same cycle as `done` is accepted.
- `phase`, `layer_idx`, `sample_idx` and `busy` are registered. The selects follow them in the same cycle.
- `fsm_rst_n` asserted mid-batch clears everything immediately. No `done` is produced.

## Configuration
- `SCHED_PERF_CNT_EN`:
  - Defined: adds output `perf_cycles` [31:0]. It clears when `start` is accepted, increments on every busy cycle including held cycles, saturates at all-ones and holds its value in IDLE.
  - Undefined: port and counter absent. All other behaviour is identical.

## Test plan
- NUM_LAYERS=2, PHASE_LEN=3, `start` with batch_size=1 and `stride_cfg`=2'b10 -> phase/layer sequence FP0, FP1, BP1, BP0, WG1, WG0, each 3 cycles; `busy` high for exactly 18 cycles; `done` on cycle 19; `select1` is 1 in BP0 and 0 in BP1.
- Defaults, batch_size=3 -> `busy` for 396 cycles; `sample_idx` steps 0→1→2 at each WG layer-0 exit; a single `done` pulse.
- `hold` high for 5 cycles mid-BP -> `phase_cnt`, layer and selects frozen; completion delayed by exactly 5 cycles.
- `abort` during WG of sample 0 -> IDLE next cycle, all selects 0, no `done`; a new `start` runs a full batch.
- batch_size=0 -> `done` the next cycle, `busy` never asserts. `start` while busy -> ignored. Reset mid-FP -> all outputs 0 immediately.
- `SCHED_PERF_CNT_EN` defined, case 1 plus 4 `hold` cycles -> `perf_cycles` = 22 at `done`.
